udp_tx: RTL and testbench

//  Builds and transmits one Ethernet II / IPv4 / UDP frame on the GMII TX side per start pulse.

---
 rtl/eth_pkg.sv | 31 +++
 rtl/crc32_d8.sv | 30 +++
 rtl/udp_tx.sv | 160 ++++++++++++++++
 tb/tb_udp_tx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP transmit constants, FSM state encoding and the CRC32 byte step.
package eth_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP    = 8'h11;
  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam logic [15:0] MIN_UDP_PAYLOAD = 16'd18;
  localparam logic [15:0] IFG_CYCLES      = 16'd12;
  localparam logic [15:0] MAX_UDP_PAYLOAD = 16'd1472;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_CSUM = 4'd1;
  localparam logic [3:0] S_PRE  = 4'd2;
  localparam logic [3:0] S_ETH  = 4'd3;
  localparam logic [3:0] S_IP   = 4'd4;
  localparam logic [3:0] S_UDP  = 4'd5;
  localparam logic [3:0] S_DATA = 4'd6;
  localparam logic [3:0] S_FCS  = 4'd7;
  localparam logic [3:0] S_IFG  = 4'd8;

  // Reflected IEEE 802.3 polynomial, one byte LSB first.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-serial CRC32 register: clear loads all ones, enable folds in one byte per cycle.
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        crc_en,
  input  logic        crc_clr,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (crc_clr)
      crc_d = '1;
    else if (crc_en)
      crc_d = crc32_step(crc_q, data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= '1;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/udp_tx.sv
// GMII transmitter for one Ethernet II/IPv4/UDP frame per start pulse.
// Optional UDP_TX_IPID_INC_EN: IP id counts frames since reset instead of staying 0000.
module udp_tx
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd10},
  parameter logic [15:0] BOARD_PORT = 16'd1234,
  parameter logic [15:0] DES_PORT   = 16'd1234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start_en,
  input  logic [15:0] tx_byte_num,
  input  logic [47:0] des_mac,
  input  logic [31:0] des_ip,
  input  logic [31:0] tx_data,
  output logic        tx_req,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        tx_done,
  output logic        busy
);

  logic [3:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d, last_cnt;
  logic        tx_req_q, tx_req_d, tx_en_q, tx_en_d, done_q;
  logic [7:0]  txd_q, byte_d;
  logic [15:0] n_q, pay_len, ip_len, udp_len, ip_id, csum_q;
  logic [47:0] mac_q;
  logic [31:0] ip_q, word_q, sum_q, ip_sum, crc, fcs_sh, word_sh;
  logic [111:0] eth_hdr, eth_sh;
  logic [159:0] ip_hdr, ip_sh;
  logic [63:0]  udp_hdr, udp_sh;

  assign pay_len = (n_q < MIN_UDP_PAYLOAD) ? MIN_UDP_PAYLOAD : n_q;
  assign ip_len  = n_q + 16'd28;
  assign udp_len = n_q + 16'd8;
  assign ip_sum  = 32'h4500 + {16'h0, ip_len} + {16'h0, ip_id} + 32'h4000
                 + {16'h0, 8'h40, IP_PROTO_UDP} + {16'h0, BOARD_IP[31:16]}
                 + {16'h0, BOARD_IP[15:0]} + {16'h0, ip_q[31:16]} + {16'h0, ip_q[15:0]};

  assign eth_hdr = {mac_q, BOARD_MAC, ETH_TYPE_IPV4};
  assign ip_hdr  = {16'h4500, ip_len, ip_id, 16'h4000, 8'h40, IP_PROTO_UDP, csum_q,
                    BOARD_IP, ip_q};
  assign udp_hdr = {BOARD_PORT, DES_PORT, udp_len, 16'h0000};
  assign eth_sh  = eth_hdr << {cnt_q[3:0], 3'b000};
  assign ip_sh   = ip_hdr << {cnt_q[4:0], 3'b000};
  assign udp_sh  = udp_hdr << {cnt_q[2:0], 3'b000};
  assign word_sh = word_q << {cnt_q[1:0], 3'b000};
  assign fcs_sh  = ~crc >> {cnt_q[1:0], 3'b000};

`ifdef UDP_TX_IPID_INC_EN
  logic [15:0] ip_id_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ip_id_q <= '0;
    else if (state_q == S_FCS && cnt_q == 16'd3)
      ip_id_q <= ip_id_q + 16'd1;
  end
  assign ip_id = ip_id_q;
`else
  assign ip_id = 16'h0000;
`endif

  always_comb begin
    case (state_q)
      S_CSUM:  last_cnt = 16'd2;
      S_PRE:   last_cnt = 16'd7;
      S_ETH:   last_cnt = 16'd13;
      S_IP:    last_cnt = 16'd19;
      S_UDP:   last_cnt = 16'd7;
      S_DATA:  last_cnt = pay_len - 16'd1;
      S_FCS:   last_cnt = 16'd3;
      S_IFG:   last_cnt = IFG_CYCLES - 16'd1;
      default: last_cnt = 16'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
      if (tx_start_en) state_d = S_CSUM;
    end else if (cnt_q == last_cnt) begin
      cnt_d   = '0;
      state_d = (state_q == S_IFG) ? S_IDLE : state_q + 4'd1;
    end
  end

  // First payload byte of each word comes straight from the FIFO; the rest from word_q.
  always_comb begin
    byte_d = 8'h00;
    case (state_q)
      S_PRE:  byte_d = (cnt_q == 16'd7) ? SFD_BYTE : PREAMBLE_BYTE;
      S_ETH:  byte_d = eth_sh[111:104];
      S_IP:   byte_d = ip_sh[159:152];
      S_UDP:  byte_d = udp_sh[63:56];
      S_DATA: if (cnt_q < n_q) byte_d = (cnt_q[1:0] == 2'd0) ? tx_data[31:24] : word_sh[31:24];
      S_FCS:  byte_d = fcs_sh[7:0];
      default: byte_d = 8'h00;
    endcase
  end

  // Word fetch leads its first byte by two cycles so the FIFO has one cycle to respond.
  assign tx_req_d = (state_q == S_UDP && cnt_q == 16'd6 && n_q != 16'd0)
                 || (state_q == S_DATA && cnt_q[1:0] == 2'd2 && (cnt_q + 16'd2) < n_q);
  assign tx_en_d  = (state_q >= S_PRE) && (state_q <= S_FCS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tx_req_q <= 1'b0;
      tx_en_q  <= 1'b0;
      txd_q    <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx_req_q <= tx_req_d;
      tx_en_q  <= tx_en_d;
      txd_q    <= tx_en_d ? byte_d : 8'h00;
      done_q   <= (state_q == S_IFG) && (cnt_q == 16'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && tx_start_en) begin
      n_q   <= (tx_byte_num > MAX_UDP_PAYLOAD) ? MAX_UDP_PAYLOAD : tx_byte_num;
      mac_q <= des_mac;
      ip_q  <= des_ip;
    end
    // Header checksum: sum, fold, then fold again and invert.
    if (state_q == S_CSUM) begin
      if (cnt_q == 16'd0)      sum_q  <= ip_sum;
      else if (cnt_q == 16'd1) sum_q  <= {16'h0, sum_q[15:0]} + {16'h0, sum_q[31:16]};
      else                     csum_q <= ~(sum_q[15:0] + {15'h0, sum_q[16]});
    end
    if (state_q == S_DATA && cnt_q[1:0] == 2'd0 && cnt_q < n_q)
      word_q <= tx_data;
  end

  crc32_d8 u_crc (
    .clk     (clk),
    .rst     (rst),
    .crc_en  ((state_q >= S_ETH) && (state_q <= S_DATA)),
    .crc_clr (state_q == S_PRE),
    .data    (byte_d),
    .crc     (crc)
  );

  assign tx_req     = tx_req_q;
  assign gmii_tx_en = tx_en_q;
  assign gmii_txd   = txd_q;
  assign tx_done    = done_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_udp_tx.sv
// Scoreboard bench for udp_tx: expected frame bytes are queued at start and popped as GMII bytes appear.
module tb_udp_tx;

  localparam logic [47:0] BMAC  = 48'h00_11_22_33_44_55;
  localparam logic [31:0] BIP   = 32'hC0A8010A;
  localparam logic [15:0] BPORT = 16'd1234;

  logic        clk = 1'b0;
  logic        rst, tx_start_en;
  logic [15:0] tx_byte_num;
  logic [47:0] des_mac;
  logic [31:0] des_ip, tx_data;
  logic        tx_req, gmii_tx_en, tx_done, busy;
  logic [7:0]  gmii_txd;

  always #4 clk = ~clk;

  udp_tx dut (
    .clk(clk), .rst(rst), .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num),
    .des_mac(des_mac), .des_ip(des_ip), .tx_data(tx_data), .tx_req(tx_req),
    .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd), .tx_done(tx_done), .busy(busy)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++)
      r = ((r[0] ^ d[b]) ? 32'hEDB88320 : 32'h0) ^ (r >> 1);
    return r;
  endfunction

  logic [7:0]  exp_q[$];
  logic [31:0] data_q[$];
  logic [7:0]  frm[$];
  int          req_cnt = 0, done_cnt = 0, en_cnt = 0, frame_cnt = 0;
  logic        prev_en = 1'b0;
  logic [31:0] mon_crc = '1;
  logic [7:0]  mon_ip[20];
  logic [15:0] exp_id = 16'h0000;

  // FIFO model and GMII monitor.
  always @(negedge clk) begin
    if (tx_req) begin
      req_cnt++;
      tx_data = (data_q.size() > 0) ? data_q.pop_front() : 32'hDEADBEEF;
    end
    if (tx_done) done_cnt++;
    if (gmii_tx_en) begin
      if (!prev_en) begin
        en_cnt = 0;
        mon_crc = '1;
        frame_cnt++;
      end
      if (exp_q.size() == 0) chk("byte_overrun", {24'h0, gmii_txd}, 32'h100);
      else chk("byte", {24'h0, gmii_txd}, {24'h0, exp_q.pop_front()});
      if (en_cnt >= 8) mon_crc = crc_step(mon_crc, gmii_txd);
      if (en_cnt >= 22 && en_cnt < 42) mon_ip[en_cnt-22] = gmii_txd;
      en_cnt++;
    end
    prev_en = gmii_tx_en;
  end

  task automatic push_be(input logic [63:0] v, input int nb);
    logic [63:0] t;
    for (int i = nb - 1; i >= 0; i--) begin
      t = v >> (8 * i);
      frm.push_back(t[7:0]);
    end
  endtask

  task automatic build(input int n, input logic [47:0] mac, input logic [31:0] ip,
                       output int ns, output int p, output int nw);
    logic [31:0] w, s, c, t;
    logic [31:0] words[$];
    logic [15:0] cs;
    ns = (n > 1472) ? 1472 : n;
    p  = (ns < 18) ? 18 : ns;
    nw = (ns + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      w = (i == 0) ? 32'h01020304 : $urandom();
      words.push_back(w);
      data_q.push_back(w);
    end
    s = 32'h4500 + (28 + ns) + exp_id + 32'h4000 + 32'h4011 + BIP[31:16] + BIP[15:0]
      + ip[31:16] + ip[15:0];
    s = s[15:0] + s[31:16];
    s = s[15:0] + s[31:16];
    cs = ~s[15:0];
    frm.delete();
    push_be(mac, 6); push_be(BMAC, 6); push_be(64'h0800, 2);
    push_be(64'h4500, 2); push_be(28 + ns, 2); push_be(exp_id, 2); push_be(64'h4000, 2);
    push_be(64'h4011, 2); push_be(cs, 2); push_be(BIP, 4); push_be(ip, 4);
    push_be(BPORT, 2); push_be(BPORT, 2); push_be(8 + ns, 2); push_be(0, 2);
    for (int i = 0; i < p; i++) begin
      t = (i < ns) ? (words[i/4] >> (8 * (3 - i % 4))) : 32'h0;
      frm.push_back(t[7:0]);
    end
    c = '1;
    foreach (frm[i]) c = crc_step(c, frm[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) begin
      t = c >> (8 * i);
      frm.push_back(t[7:0]);
    end
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (frm[i]) exp_q.push_back(frm[i]);
  endtask

  task automatic start_pulse(input int n, input logic [47:0] mac, input logic [31:0] ip);
    @(posedge clk); #1;
    tx_byte_num = n[15:0]; des_mac = mac; des_ip = ip; tx_start_en = 1'b1;
    @(posedge clk); #1;
    tx_start_en = 1'b0; tx_byte_num = 16'hFFFF; des_mac = '1; des_ip = '1;
  endtask

  task automatic send(input int n, input logic [47:0] mac, input logic [31:0] ip, input bit poke);
    int ns, p, nw, lat, t, fstart;
    logic [31:0] s;
    build(n, mac, ip, ns, p, nw);
    req_cnt = 0; done_cnt = 0; fstart = frame_cnt;
    start_pulse(n, mac, ip);
    lat = 0;
    while (!gmii_tx_en && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, 4);
    if (poke) begin
      repeat (50) @(posedge clk);
      start_pulse(7, 48'h0A0B0C0D0E0F, 32'h01010101);
    end
    t = 0;
    while (!tx_done && t < 4000) begin @(posedge clk); #1; t++; end
    chk("done_seen", tx_done, 1);
    t = 0;
    while (busy && t < 40) begin @(posedge clk); #1; t++; end
    chk("ifg_cycles", t, 11);
    chk("exp_left", exp_q.size(), 0);
    chk("req_cnt", req_cnt, nw);
    chk("done_cnt", done_cnt, 1);
    chk("tx_en_len", en_cnt, 8 + 14 + 20 + 8 + p + 4);
    chk("frames", frame_cnt, fstart + 1);
    chk("fcs_residue", mon_crc, 32'hDEBB20E3);
    chk("ip_len", {mon_ip[2], mon_ip[3]}, 28 + ns);
    chk("ip_id", {mon_ip[4], mon_ip[5]}, exp_id);
    s = 0;
    for (int i = 0; i < 10; i++) s += {mon_ip[2*i], mon_ip[2*i+1]};
    s = s[15:0] + s[31:16];
    s = s[15:0] + s[31:16];
    chk("ip_csum", s[15:0], 16'hFFFF);
    exp_q.delete();
    data_q.delete();
`ifdef UDP_TX_IPID_INC_EN
    exp_id = exp_id + 16'd1;
`endif
  endtask

  task automatic abort_frame();
    int ns, p, nw, t;
    build(100, 48'hA0A1A2A3A4A5, 32'hC0A80177, ns, p, nw);
    req_cnt = 0;
    start_pulse(100, 48'hA0A1A2A3A4A5, 32'hC0A80177);
    t = 0;
    while (req_cnt < 3 && t < 200) begin @(posedge clk); #1; t++; end
    chk("abort_reached_data", (req_cnt >= 3), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_tx_en", gmii_tx_en, 0);
    chk("rst_txd", gmii_txd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", tx_req, 0);
    exp_q.delete();
    data_q.delete();
    exp_id = 16'h0000;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tx_start_en = 1'b0; tx_byte_num = '0; des_mac = '0; des_ip = '0; tx_data = '0;
    #20;
    chk("reset_tx_en", gmii_tx_en, 0);
    chk("reset_txd", gmii_txd, 0);
    chk("reset_req", tx_req, 0);
    chk("reset_done", tx_done, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(4, 48'hFF_EE_DD_CC_BB_AA, 32'hC0A80166, 1'b0);
    send(5, 48'h02_03_04_05_06_07, 32'hC0A80166, 1'b0);
    send(0, 48'h10_20_30_40_50_60, 32'h0A000001, 1'b0);
    send(1472, 48'h12_34_56_78_9A_BC, 32'hC0A80102, 1'b1);
    send(2000, 48'h12_34_56_78_9A_BC, 32'hC0A80102, 1'b0);
    send($urandom_range(19, 64), 48'h5A_5A_5A_5A_5A_5A, 32'hAC100001, 1'b0);
    abort_frame();
    send(30, 48'hCA_FE_BA_BE_00_01, 32'hC0A80103, 1'b0);
    for (int k = 0; k < 3; k++) send(10, 48'h00_AA_BB_CC_DD_EE, 32'hC0A80104, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
